serial_adder_ctrl: RTL and testbench

Multi-cycle add/subtract sequencer that drives one 1-bit full-adder cell (sum, carry, a, b, cin) bit-serially over WIDTH cycles, LSB first. It gives the ALU a WIDTH-bit add/sub using only a single adder cell. A start/busy/done handshake lets the CPU control logic issue one operation at a time. Sits in cpu/alu between the operand latches and the ALU result mux.

---
 rtl/serial_adder_ctrl.sv | 67 ++++++
 tb/tb_serial_adder_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/sub sequencer around a single full-adder cell, LSB first over WIDTH cycles
//   clk, rst_n (async, active-low)
//   start, sub, op_a, op_b : request and operands, sampled in IDLE or DONE
//   busy, done             : busy while running, done pulses one cycle with the valid result
//   result, carry_out, overflow : sum/difference, final carry (1 = no borrow on sub), signed overflow
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CNT_W-1:0] cnt;
  logic c_reg, acc, last, s, cy;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign acc  = start && state != RUN;
  assign last = busy && cnt == CNT_W'(WIDTH - 1);
  assign s    = a_sh[0] ^ b_sh[0] ^ c_reg;
  assign cy   = (a_sh[0] & b_sh[0]) | (c_reg & (a_sh[0] ^ b_sh[0]));
  always_comb begin
    state_nx = acc ? RUN : busy ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      c_reg     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (acc) begin
      a_sh   <= op_a;
      b_sh   <= sub ? ~op_b : op_b;
      c_reg  <= sub;
      cnt    <= '0;
      result <= '0;
    end else if (busy) begin
      result <= {s, result[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c_reg  <= cy;
      cnt    <= last ? cnt : cnt + CNT_W'(1);
      if (last) begin
        carry_out <= cy;
        overflow  <= c_reg ^ cy;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed scoreboard bench for serial_adder_ctrl at WIDTH=8
module tb_serial_adder_ctrl;
  typedef struct packed {logic [7:0] r; logic co; logic ov;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [7:0] op_a = '0, op_b = '0, result;
  logic busy, done, carry_out, overflow;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0, done_cnt = 0, snap;
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bb;
    logic [8:0] full;
    exp_t e;
    bb = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, s};
    e.r = full[7:0];
    e.co = full[8];
    e.ov = (a[7] == bb[7]) && (full[7] != a[7]);
    return e;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("carry_out", carry_out, e.co);
        chk("overflow", overflow, e.ov);
      end
    end
  end
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input bit accept);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    if (accept) sb.push_back(model(a, b, s));
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(tag, seen, 1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_carry"}, carry_out, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask
  initial begin
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h0F, 8'h01, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_busy", {busy, done}, 2'b10);
    end
    @(negedge clk);
    chk("t1_done_latency", {busy, done}, 2'b01);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    issue(8'hFF, 8'h01, 0, 1);
    wait_done("t2a_done");
    issue(8'h7F, 8'h01, 0, 1);
    wait_done("t2b_done");
    issue(8'h05, 8'h07, 1, 1);
    wait_done("t3a_done");
    issue(8'h80, 8'h01, 1, 1);
    wait_done("t3b_done");
    @(negedge clk);
    snap = done_cnt;
    issue(8'h10, 8'h20, 0, 1);
    repeat (2) @(negedge clk);
    issue(8'hFF, 8'hFF, 0, 0);
    wait_done("t4_done");
    repeat (4) @(negedge clk);
    chk("t4_single_done", done_cnt - snap, 1);
    issue(8'h0A, 8'h0B, 0, 1);
    wait_done("t5a_done");
    chk("t5_busy_in_done", busy, 0);
    start = 1'b1; op_a = 8'h01; op_b = 8'h01; sub = 1'b0;
    sb.push_back(model(8'h01, 8'h01, 0));
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_busy_next", busy, 1);
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("t5_not_early", done, 0);
    wait_done("t5b_done");
    @(negedge clk);
    issue(8'h33, 8'h44, 0, 1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("t6_async");
    sb.delete();
    snap = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_cnt - snap, 0);
    issue(8'h03, 8'h04, 0, 1);
    wait_done("t6_done");
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
